// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the decode stage and its neighbours.
//   - XLEN / NREGS / REG_AW: datapath width, register count, register index width.
//   - RV32I opcode values used for immediate selection.
//   - Encodings driven onto the fetch stage's PC_op input.
//   - Decode FSM state encodings.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] OP     = 7'h33;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_LOAD = 2'b01,
        PC_HOLD = 2'b10
    } pc_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } dec_state_e;

    // True when a register index refers to a real (writable) register.
    function automatic logic reg_nonzero(input logic [REG_AW-1:0] idx);
        return (idx != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: the ID/EX boundary bundle produced by the decode stage.
//   master : driven by decode_stage (all id_* fields)
//   slave  : consumed by the execute stage
// A slot with id_valid=0 carries all-zero fields and is treated as a NOP.
interface decode_stage_if
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;
    logic [4:0]      id_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;

    modport master (
        output id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_funct3, id_funct7, id_imm, id_rs1_data, id_rs2_data
    );

    modport slave (
        input  id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_funct3, id_funct7, id_imm, id_rs1_data, id_rs2_data
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// reg_file: NREGS x XLEN register file, two combinational read ports and one
// write port.
//   clk, rst        : clock, asynchronous active-low reset (clears all entries)
//   we, wr_idx, wr_data      : write port, ignored for index 0
//   rd_a_idx/rd_a_data, rd_b_idx/rd_b_data : read ports
// A read of the index being written in the same cycle returns the write data,
// so an instruction decoded alongside its producer's write-back sees the new value.
module reg_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_a_idx,
    output logic [XLEN-1:0] rd_a_data,
    input  logic [AW-1:0]   rd_b_idx,
    output logic [XLEN-1:0] rd_b_data
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            wr_en_s;

    // Writes to x0 are discarded.
    assign wr_en_s = we & (wr_idx != {AW{1'b0}});

    // Register storage: cleared on reset, written on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[wr_idx] <= wr_data;
        end
    end

    // Read port A with x0 forced to zero and same-cycle write bypass.
    always_comb begin
        rd_a_data = {XLEN{1'b0}};
        if (rd_a_idx == {AW{1'b0}}) begin
            rd_a_data = {XLEN{1'b0}};
        end else if (wr_en_s && (wr_idx == rd_a_idx)) begin
            rd_a_data = wr_data;
        end else begin
            rd_a_data = regs_r[rd_a_idx];
        end
    end

    // Read port B with x0 forced to zero and same-cycle write bypass.
    always_comb begin
        rd_b_data = {XLEN{1'b0}};
        if (rd_b_idx == {AW{1'b0}}) begin
            rd_b_data = {XLEN{1'b0}};
        end else if (wr_en_s && (wr_idx == rd_b_idx)) begin
            rd_b_data = wr_data;
        end else begin
            rd_b_data = regs_r[rd_b_idx];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode sitting between fetch and execute.
//   clk, rst            : clock, asynchronous active-low reset
//   instr_in, pc_in     : instruction and its PC from fetch
//   ex_mem_read, ex_rd  : load currently in EX and its destination (load-use check)
//   flush, flush_target : taken branch/jump resolved in EX and its target
//   wb_we, wb_rd, wb_data : register-file write-back port
//   pc_op_out, pc_load_out : combinational PC control back to fetch
//   id_bus              : registered ID/EX slot (decode_stage_if master)
// After reset and after every flush the FSM spends one cycle in KILL, dropping
// the instruction that fetch presents, since it was fetched from the wrong path.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_target,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [1:0]      pc_op_out,
    output logic [XLEN-1:0] pc_load_out,
    decode_stage_if.master  id_bus
);

    dec_state_e      state_r;
    dec_state_e      state_nxt_s;
    pc_op_e          pc_op_s;
    logic [XLEN-1:0] pc_load_s;
    logic            capture_s;
    logic            hazard_s;

    logic [6:0]      opcode_s;
    logic [4:0]      rd_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    assign opcode_s = instr_in[6:0];
    assign rd_s     = instr_in[11:7];
    assign funct3_s = instr_in[14:12];
    assign rs1_s    = instr_in[19:15];
    assign rs2_s    = instr_in[24:20];
    assign funct7_s = instr_in[31:25];

    // Load-use check ignores the instruction format, so an unused rs2 field
    // may cause a harmless extra stall.
    assign hazard_s = ex_mem_read & reg_nonzero(ex_rd) &
                      ((ex_rd == rs1_s) | (ex_rd == rs2_s));

    // Immediate generation, sign-extended from instruction bit 31.
    always_comb begin
        imm_s = {XLEN{1'b0}};
        case (opcode_s)
            OP_IMM, LOAD, JALR:
                imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
            STORE:
                imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            BRANCH:
                imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25],
                         instr_in[11:8], 1'b0};
            LUI, AUIPC:
                imm_s = {instr_in[31:12], 12'h000};
            JAL:
                imm_s = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20],
                         instr_in[30:21], 1'b0};
            default:
                imm_s = {XLEN{1'b0}};
        endcase
    end

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_we),
        .wr_idx    (wb_rd),
        .wr_data   (wb_data),
        .rd_a_idx  (rs1_s),
        .rd_a_data (rs1_data_s),
        .rd_b_idx  (rs2_s),
        .rd_b_data (rs2_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_KILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and PC control: flush beats hazard beats normal decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_op_s     = PC_INC;
        pc_load_s   = {XLEN{1'b0}};
        capture_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    pc_op_s     = PC_LOAD;
                    pc_load_s   = flush_target;
                    state_nxt_s = ST_KILL;
                end else if (hazard_s) begin
                    pc_op_s     = PC_HOLD;
                end else begin
                    capture_s   = 1'b1;
                end
            end
            ST_KILL: begin
                if (flush) begin
                    pc_op_s     = PC_LOAD;
                    pc_load_s   = flush_target;
                    state_nxt_s = ST_KILL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_KILL;
            end
        endcase
    end

    // PC controls read as increment/zero while reset is held, whatever flush does.
    always_comb begin
        pc_op_out   = PC_INC;
        pc_load_out = {XLEN{1'b0}};
        if (!rst) begin
            pc_op_out   = PC_INC;
            pc_load_out = {XLEN{1'b0}};
        end else begin
            pc_op_out   = pc_op_s;
            pc_load_out = pc_load_s;
        end
    end

    // ID/EX boundary register: captures the decode or inserts an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_bus.id_valid    <= 1'b0;
            id_bus.id_pc       <= {XLEN{1'b0}};
            id_bus.id_opcode   <= 7'h00;
            id_bus.id_rd       <= 5'd0;
            id_bus.id_rs1      <= 5'd0;
            id_bus.id_rs2      <= 5'd0;
            id_bus.id_funct3   <= 3'd0;
            id_bus.id_funct7   <= 7'h00;
            id_bus.id_imm      <= {XLEN{1'b0}};
            id_bus.id_rs1_data <= {XLEN{1'b0}};
            id_bus.id_rs2_data <= {XLEN{1'b0}};
        end else if (capture_s) begin
            id_bus.id_valid    <= 1'b1;
            id_bus.id_pc       <= pc_in;
            id_bus.id_opcode   <= opcode_s;
            id_bus.id_rd       <= rd_s;
            id_bus.id_rs1      <= rs1_s;
            id_bus.id_rs2      <= rs2_s;
            id_bus.id_funct3   <= funct3_s;
            id_bus.id_funct7   <= funct7_s;
            id_bus.id_imm      <= imm_s;
            id_bus.id_rs1_data <= rs1_data_s;
            id_bus.id_rs2_data <= rs2_data_s;
        end else begin
            id_bus.id_valid    <= 1'b0;
            id_bus.id_pc       <= {XLEN{1'b0}};
            id_bus.id_opcode   <= 7'h00;
            id_bus.id_rd       <= 5'd0;
            id_bus.id_rs1      <= 5'd0;
            id_bus.id_rs2      <= 5'd0;
            id_bus.id_funct3   <= 3'd0;
            id_bus.id_funct7   <= 7'h00;
            id_bus.id_imm      <= {XLEN{1'b0}};
            id_bus.id_rs1_data <= {XLEN{1'b0}};
            id_bus.id_rs2_data <= {XLEN{1'b0}};
        end
    end

endmodule
